// File: rtl/mem_tbus_arb_pkg.sv
// Shared tbus definitions for the load/store-queue arbiter in front of the dcache.
package mem_tbus_arb_pkg;

    localparam int TBUS_ADDR_W   = 64;
    localparam int TBUS_DATA_W   = 64;
    localparam int TBUS_MASK_W   = 64;
    localparam int TBUS_OPTYPE_W = 2;

    localparam logic [TBUS_OPTYPE_W-1:0] TBUS_READ  = 2'b00;
    localparam logic [TBUS_OPTYPE_W-1:0] TBUS_WRITE = 2'b01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_LD = 2'd1,
        BUSY_ST = 2'd2,
        DRAIN   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_tbus_arb.sv
// Arbitrates load-unit and store-queue tbus requests onto one dcache port, one
// transaction at a time, and routes the response back to the owning requester.
module mem_tbus_arb
    import mem_tbus_arb_pkg::*;
#(
    parameter int ADDR_W       = TBUS_ADDR_W,
    parameter int DATA_W       = TBUS_DATA_W,
    parameter int OPTYPE_W     = TBUS_OPTYPE_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset_n,

    input  logic                load2arb_tbus_index_valid,
    output logic                load2arb_tbus_index_ready,
    input  logic [ADDR_W-1:0]   load2arb_tbus_index,
    input  logic [DATA_W-1:0]   load2arb_tbus_write_data,
    input  logic [63:0]         load2arb_tbus_write_mask,
    input  logic [OPTYPE_W-1:0] load2arb_tbus_operation_type,
    output logic [DATA_W-1:0]   load2arb_tbus_read_data,
    output logic                load2arb_tbus_operation_done,

    input  logic                sq2arb_tbus_index_valid,
    output logic                sq2arb_tbus_index_ready,
    input  logic [ADDR_W-1:0]   sq2arb_tbus_index,
    input  logic [DATA_W-1:0]   sq2arb_tbus_write_data,
    input  logic [63:0]         sq2arb_tbus_write_mask,
    input  logic [OPTYPE_W-1:0] sq2arb_tbus_operation_type,
    output logic                sq2arb_tbus_operation_done,

    output logic                arb2dcache_tbus_index_valid,
    input  logic                arb2dcache_tbus_index_ready,
    output logic [ADDR_W-1:0]   arb2dcache_tbus_index,
    output logic [DATA_W-1:0]   arb2dcache_tbus_write_data,
    output logic [63:0]         arb2dcache_tbus_write_mask,
    output logic [OPTYPE_W-1:0] arb2dcache_tbus_operation_type,
    input  logic [DATA_W-1:0]   arb2dcache_tbus_read_data,
    input  logic                arb2dcache_tbus_operation_done,

    input  logic                mem2dcache_flush
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_reg, state_next;
    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

    logic ld_elig, store_wins, load_wins, in_idle, grant_valid, fire, ld_owner;

    always_comb begin
        ld_elig     = load2arb_tbus_index_valid & ~mem2dcache_flush;
        store_wins  = sq2arb_tbus_index_valid & ~(ld_elig && (starve_cnt_reg == CNT_MAX));
        load_wins   = ~store_wins & ld_elig;
        // Outputs are held at zero while reset is asserted, not just after the edge.
        in_idle     = reset_n & (state_reg == IDLE);
        grant_valid = in_idle & (store_wins | load_wins);
        fire        = grant_valid & arb2dcache_tbus_index_ready;
        ld_owner    = reset_n & (state_reg == BUSY_LD) & ~mem2dcache_flush;
    end

    always_comb begin
        arb2dcache_tbus_index_valid    = grant_valid;
        arb2dcache_tbus_index          = '0;
        arb2dcache_tbus_write_data     = '0;
        arb2dcache_tbus_write_mask     = '0;
        arb2dcache_tbus_operation_type = '0;
        if (in_idle && store_wins) begin
            arb2dcache_tbus_index          = sq2arb_tbus_index;
            arb2dcache_tbus_write_data     = sq2arb_tbus_write_data;
            arb2dcache_tbus_write_mask     = sq2arb_tbus_write_mask;
            arb2dcache_tbus_operation_type = sq2arb_tbus_operation_type;
        end else if (in_idle && load_wins) begin
            arb2dcache_tbus_index          = load2arb_tbus_index;
            arb2dcache_tbus_write_data     = load2arb_tbus_write_data;
            arb2dcache_tbus_write_mask     = load2arb_tbus_write_mask;
            arb2dcache_tbus_operation_type = load2arb_tbus_operation_type;
        end
    end

    assign sq2arb_tbus_index_ready      = in_idle & store_wins & arb2dcache_tbus_index_ready;
    assign load2arb_tbus_index_ready    = in_idle & load_wins & arb2dcache_tbus_index_ready;
    assign load2arb_tbus_operation_done = ld_owner & arb2dcache_tbus_operation_done;
    assign load2arb_tbus_read_data      = ld_owner ? arb2dcache_tbus_read_data : '0;
    assign sq2arb_tbus_operation_done   = reset_n & (state_reg == BUSY_ST) & arb2dcache_tbus_operation_done;

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (fire) begin
                    state_next = store_wins ? BUSY_ST : BUSY_LD;
                end
                if (fire && load_wins) begin
                    starve_cnt_next = '0;
                end else if (fire && store_wins && ld_elig) begin
                    if (starve_cnt_reg != CNT_MAX) begin
                        starve_cnt_next = starve_cnt_reg + 1'b1;
                    end
                end else if (!load2arb_tbus_index_valid) begin
                    starve_cnt_next = '0;
                end
            end
            // A flush coinciding with done still returns straight to IDLE.
            BUSY_LD: begin
                if (arb2dcache_tbus_operation_done) begin
                    state_next = IDLE;
                end else if (mem2dcache_flush) begin
                    state_next = DRAIN;
                end
            end
            BUSY_ST, DRAIN: begin
                if (arb2dcache_tbus_operation_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // A dcache done with nothing outstanding is a protocol violation.
    no_done_in_idle: assert property (@(posedge clock) disable iff (!reset_n)
        !((state_reg == IDLE) && arb2dcache_tbus_operation_done));

endmodule
